sea_de_iter: RTL

//  Iterative, handshaked SEA-style Feistel decryption core: one round per clock.
//  It is the inverse of the team's SEA encryption datapath and uses 48-bit halves and a 48-bit key.
//  It sits between a ciphertext source and a plaintext sink in tt_um_scalable-class top levels.
//  It replaces the unrolled combinational decryptor with a small sequential engine.

---
 rtl/sea_de_iter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sea_de_iter.sv
// Iterative SEA-style Feistel decryption core: one round per enabled clock,
// valid/ready handshake on both sides, outputs hold the last plaintext.
module sea_de_iter #(
    parameter int unsigned WB = 8,
    parameter int unsigned NB = 6,
    parameter int unsigned NR = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NB*WB-1:0]  ci_l,
    input  logic [NB*WB-1:0]  ci_r,
    input  logic [NB*WB-1:0]  ki,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NB*WB-1:0]  lio,
    output logic [NB*WB-1:0]  rio,
    output logic              busy
);

    localparam int unsigned W  = NB * WB;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ctr_q;
    logic [W-1:0]    l_q;
    logic [W-1:0]    r_q;
    logic [W-1:0]    k_q;
    logic [W-1:0]    lio_q;
    logic [W-1:0]    rio_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [W-1:0]    rk_c;
    logic [W-1:0]    f_c;
    logic [W-1:0]    nl_c;

    // Rotate by one word: word j -> word j+1, top word wraps to word 0.
    function automatic logic [W-1:0] rotw(input logic [W-1:0] x);
        return {x[W-WB-1:0], x[W-1 -: WB]};
    endfunction

    function automatic logic [W-1:0] rotw_n(input logic [W-1:0] x, input logic [CW-1:0] n);
        logic [W-1:0] r;
        r = x;
        for (int s = 0; s < int'(NB) - 1; s++) begin
            if (s < int'(n)) begin
                r = rotw(r);
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] add_w(input logic [W-1:0] x, input logic [W-1:0] k);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < int'(NB); j++) begin
            r[j*WB +: WB] = x[j*WB +: WB] + k[j*WB +: WB];
        end
        return r;
    endfunction

    function automatic logic [2:0] sbox3(input logic [2:0] v);
        logic [2:0] y;
        case (v)
            3'd0:    y = 3'd0;
            3'd1:    y = 3'd5;
            3'd2:    y = 3'd6;
            3'd3:    y = 3'd7;
            3'd4:    y = 3'd4;
            3'd5:    y = 3'd3;
            3'd6:    y = 3'd1;
            default: y = 3'd2;
        endcase
        return y;
    endfunction

    // Bitsliced S-box: each word triple forms WB independent 3-bit lookups.
    function automatic logic [W-1:0] sbox(input logic [W-1:0] x);
        logic [W-1:0] r;
        logic [2:0]   y;
        r = '0;
        for (int t = 0; t < int'(NB / 3); t++) begin
            for (int b = 0; b < int'(WB); b++) begin
                y = sbox3({x[(3*t+2)*int'(WB)+b], x[(3*t+1)*int'(WB)+b], x[(3*t)*int'(WB)+b]});
                r[(3*t)*int'(WB)+b]   = y[0];
                r[(3*t+1)*int'(WB)+b] = y[1];
                r[(3*t+2)*int'(WB)+b] = y[2];
            end
        end
        return r;
    endfunction

    // Round datapath for round index ctr_q.
    always_comb begin
        rk_c = rotw_n(k_q, ctr_q % CW'(NB)) ^ {NB{WB'(ctr_q)}};
        f_c  = rotw(sbox(add_w(l_q, rk_c)));
        nl_c = r_q ^ f_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            k_q         <= '0;
            lio_q       <= '0;
            rio_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        l_q     <= ci_l;
                        r_q     <= ci_r;
                        k_q     <= ki;
                        ctr_q   <= CW'(NR - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    l_q <= nl_c;
                    r_q <= l_q;
                    if (ctr_q == '0) begin
                        lio_q       <= nl_c;
                        rio_q       <= l_q;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        ctr_q <= ctr_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Acceptance must follow ena within the same cycle, so in_ready is decoded.
    assign in_ready  = ena && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign lio       = lio_q;
    assign rio       = rio_q;

endmodule
